// File: rtl/fp_addsub_pipe.sv
// Three-stage FP adder/subtractor: S1 unpack/swap/align, S2 add/sub, S3 normalise/round/pack.
// Latency 3 clk; stages stall together whenever a valid result is not taken (in_ready = en).
module fp_addsub_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   in0,
    input  logic [EXP_W+MAN_W:0]   in1,
    input  logic                   op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   out,
    output logic [2:0]             flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam int AW   = MAN_W + 4;
    localparam int SUMW = MAN_W + 5;
    localparam int LZ_W = $clog2(AW + 1);
    localparam int XW   = EXP_W + 8;
    localparam logic [XW-1:0] EXP_TOP = XW'(2 * BIAS + 1);

    function automatic logic [LZ_W-1:0] lzc_f(input logic [AW-1:0] v);
        logic [LZ_W-1:0] n;
        logic            found;
        n     = '0;
        found = 1'b0;
        for (int i = AW - 1; i >= 0; i--) begin
            if (!found) begin
                if (v[i]) found = 1'b1;
                else      n = n + LZ_W'(1);
            end
        end
        return n;
    endfunction

    logic en;
    logic out_vld_q;
    logic [W-1:0] out_q;
    logic [2:0]   flags_q;

    assign en        = !out_vld_q || out_ready;
    assign in_ready  = en;
    assign out_valid = out_vld_q;
    assign out       = out_q;
    assign flags     = flags_q;

    // ---------------- S1: unpack, compare, swap, align
    logic             sa, sb, a_zero, b_zero, a_max, b_max, a_big;
    logic [EXP_W-1:0] ea, eb, e_small, dsh;
    logic [MAN_W-1:0] ma, mb;
    logic [MAN_W:0]   sig_a, sig_b, sig_big, sig_small;
    logic [MAN_W+2:0] ext_small, sh_small;
    logic             s1_sign_d, s1_sub_d, s1_zsign_d, s1_nan_d, s1_inf_d, s1_inf_sign_d;
    logic [EXP_W-1:0] s1_exp_d;
    logic [AW-1:0]    s1_big_d, s1_small_d;

    always_comb begin
        sa     = in0[W-1];
        ea     = in0[W-2 -: EXP_W];
        ma     = in0[MAN_W-1:0];
        sb     = in1[W-1] ^ op;
        eb     = in1[W-2 -: EXP_W];
        mb     = in1[MAN_W-1:0];
        a_zero = (ea == '0);
        b_zero = (eb == '0);
        a_max  = &ea;
        b_max  = &eb;
        sig_a  = a_zero ? '0 : {1'b1, ma};
        sig_b  = b_zero ? '0 : {1'b1, mb};
        // Flushed operands compare as magnitude 0 so a denormal never wins the swap.
        a_big  = (a_zero ? '0 : {ea, ma}) >= (b_zero ? '0 : {eb, mb});

        s1_sign_d = a_big ? sa : sb;
        s1_exp_d  = a_big ? ea : eb;
        e_small   = a_big ? eb : ea;
        sig_big   = a_big ? sig_a : sig_b;
        sig_small = a_big ? sig_b : sig_a;
        dsh       = s1_exp_d - e_small;
        ext_small = {sig_small, 2'b00};
        sh_small  = ext_small >> dsh;
        s1_small_d = {sh_small, (sh_small << dsh) != ext_small};
        s1_big_d   = {sig_big, 3'b000};
        s1_sub_d   = sa ^ sb;
        s1_zsign_d = sa & sb;

        s1_nan_d = (a_max && ma != '0) || (b_max && mb != '0) ||
                   (a_max && b_max && (sa != sb));
        s1_inf_d      = a_max || b_max;
        s1_inf_sign_d = a_max ? sa : sb;
    end

    logic             s1_vld_q, s1_sign_q, s1_sub_q, s1_zsign_q, s1_nan_q, s1_inf_q, s1_inf_sign_q;
    logic [EXP_W-1:0] s1_exp_q;
    logic [AW-1:0]    s1_big_q, s1_small_q;

    // ---------------- S2: signed mantissa add/sub (big >= small, so never negative)
    logic [SUMW-1:0] s2_sum_d;
    assign s2_sum_d = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, s1_small_q})
                               : ({1'b0, s1_big_q} + {1'b0, s1_small_q});

    logic             s2_vld_q, s2_sign_q, s2_zsign_q, s2_nan_q, s2_inf_q, s2_inf_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SUMW-1:0]  s2_sum_q;

    // ---------------- S3: normalise, round to nearest even, pack, flags
    logic             carry, rnd;
    logic [LZ_W-1:0]  lz;
    logic [AW-1:0]    norm;
    logic [XW-1:0]    exp_n, exp_r;
    logic [MAN_W+1:0] mant;
    logic [MAN_W-1:0] man_r;
    logic [W-1:0]     res_d;
    logic [2:0]       flags_d;

    always_comb begin
        carry = s2_sum_q[SUMW-1];
        lz    = lzc_f(s2_sum_q[AW-1:0]);
        if (carry) begin
            norm  = {s2_sum_q[SUMW-1:2], |s2_sum_q[1:0]};
            exp_n = XW'(s2_exp_q) + XW'(1);
        end else begin
            norm  = s2_sum_q[AW-1:0] << lz;
            exp_n = XW'(s2_exp_q) - XW'(lz);
        end
        rnd   = norm[2] & (norm[1] | norm[0] | norm[3]);
        mant  = {1'b0, norm[AW-1:3]} + (MAN_W+2)'(rnd);
        exp_r = exp_n + XW'(mant[MAN_W+1]);
        man_r = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];

        res_d   = {s2_sign_q, exp_r[EXP_W-1:0], man_r};
        flags_d = 3'b000;
        if (s2_nan_q) begin
            res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            flags_d = 3'b100;
        end else if (s2_inf_q) begin
            res_d = {s2_inf_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (s2_sum_q == '0) begin
            res_d = {s2_zsign_q, {(W-1){1'b0}}};
        end else if (!exp_r[XW-1] && exp_r >= EXP_TOP) begin
            res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags_d = 3'b010;
        end else if (exp_r[XW-1] || exp_r == '0) begin
            res_d   = {s2_sign_q, {(W-1){1'b0}}};
            flags_d = 3'b001;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q      <= 1'b0;
            s1_sign_q     <= 1'b0;
            s1_sub_q      <= 1'b0;
            s1_zsign_q    <= 1'b0;
            s1_nan_q      <= 1'b0;
            s1_inf_q      <= 1'b0;
            s1_inf_sign_q <= 1'b0;
            s1_exp_q      <= '0;
            s1_big_q      <= '0;
            s1_small_q    <= '0;
            s2_vld_q      <= 1'b0;
            s2_sign_q     <= 1'b0;
            s2_zsign_q    <= 1'b0;
            s2_nan_q      <= 1'b0;
            s2_inf_q      <= 1'b0;
            s2_inf_sign_q <= 1'b0;
            s2_exp_q      <= '0;
            s2_sum_q      <= '0;
            out_vld_q     <= 1'b0;
            out_q         <= '0;
            flags_q       <= '0;
        end else if (en) begin
            s1_vld_q      <= in_valid;
            s1_sign_q     <= s1_sign_d;
            s1_sub_q      <= s1_sub_d;
            s1_zsign_q    <= s1_zsign_d;
            s1_nan_q      <= s1_nan_d;
            s1_inf_q      <= s1_inf_d;
            s1_inf_sign_q <= s1_inf_sign_d;
            s1_exp_q      <= s1_exp_d;
            s1_big_q      <= s1_big_d;
            s1_small_q    <= s1_small_d;
            s2_vld_q      <= s1_vld_q;
            s2_sign_q     <= s1_sign_q;
            s2_zsign_q    <= s1_zsign_q;
            s2_nan_q      <= s1_nan_q;
            s2_inf_q      <= s1_inf_q;
            s2_inf_sign_q <= s1_inf_sign_q;
            s2_exp_q      <= s1_exp_q;
            s2_sum_q      <= s2_sum_d;
            out_vld_q     <= s2_vld_q;
            out_q         <= res_d;
            flags_q       <= flags_d;
        end
    end
endmodule
